// File: rtl/save_pkg.sv
// Shared definitions for the save_store write-back engine: instruction field
// layout, buffer geometry, FSM state encoding and the expected-length helper.
package save_pkg;

    localparam int FIELD_W        = 16;
    localparam int BUF_START_LSB  = 32;
    localparam int BUF_LEN_LSB    = 48;
    localparam int DRAM_START_LSB = 64;
    localparam int DRAM_BYTES_LSB = 80;

    localparam int BEATS_PER_WORD = 16;
    localparam int BEAT_IDX_W     = 4;
    localparam int BUF_ADDR_W     = 13;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } save_state_t;

    // Bytes a transfer of len buffer words should cover, truncated to 32 bits.
    function automatic logic [31:0] save_len_bytes(input logic [FIELD_W-1:0] len,
                                                   input int unsigned beat_bytes);
        logic [31:0] per_word;
        per_word = 32'(BEATS_PER_WORD * beat_bytes);
        return 32'(len) * per_word;
    endfunction

endpackage

// File: rtl/save_unpacker.sv
// Unpacks wide buffer words into AXI4-Stream beats: one staging word plus a
// 16-beat shift register that reloads on the beat-15 handshake for full rate.
module save_unpacker
    import save_pkg::*;
#(
    parameter int W = 512
) (
    input  logic                        kernel_clk,
    input  logic                        kernel_rst,
    input  logic                        rd_valid_i,
    input  logic                        rd_last_i,
    input  logic [BEATS_PER_WORD*W-1:0] rd_data_i,
    output logic                        slot_busy_o,
    output logic                        slot_take_o,
    output logic                        last_hs_o,
    output logic                        m_axis_tvalid_o,
    input  logic                        m_axis_tready_i,
    output logic [W-1:0]                m_axis_tdata_o,
    output logic                        m_axis_tlast_o
);

    localparam int WW = BEATS_PER_WORD * W;

    logic [WW-1:0]         stg_q, stg_d, sh_q, sh_d;
    logic                  stg_vld_q, stg_vld_d, stg_last_q, stg_last_d;
    logic                  sh_vld_q, sh_vld_d, sh_last_q, sh_last_d;
    logic [BEAT_IDX_W-1:0] beat_q, beat_d;

    logic          slot_vld, slot_last, hs, word_end, load;
    logic [WW-1:0] slot_data;

    // The slot is either the word arriving from the buffer this cycle or the
    // staged one; the read issue logic guarantees they are never both live.
    always_comb begin
        slot_vld  = stg_vld_q | rd_valid_i;
        slot_data = rd_valid_i ? rd_data_i : stg_q;
        slot_last = rd_valid_i ? rd_last_i : stg_last_q;
        hs        = sh_vld_q & m_axis_tready_i;
        word_end  = hs & (beat_q == BEAT_IDX_W'(BEATS_PER_WORD - 1));
        load      = slot_vld & (~sh_vld_q | word_end);

        sh_d       = sh_q;
        sh_vld_d   = sh_vld_q;
        sh_last_d  = sh_last_q;
        beat_d     = beat_q;
        stg_d      = stg_q;
        stg_vld_d  = stg_vld_q;
        stg_last_d = stg_last_q;

        if (load) begin
            sh_d      = slot_data;
            sh_vld_d  = 1'b1;
            sh_last_d = slot_last;
            beat_d    = '0;
        end else if (hs) begin
            sh_d   = sh_q >> W;
            beat_d = beat_q + 1'b1;
            if (word_end) begin
                sh_vld_d = 1'b0;
            end
        end

        if (rd_valid_i && !load) begin
            stg_d      = rd_data_i;
            stg_vld_d  = 1'b1;
            stg_last_d = rd_last_i;
        end else if (load) begin
            stg_vld_d = 1'b0;
        end
    end

    always_ff @(posedge kernel_clk or posedge kernel_rst) begin
        if (kernel_rst) begin
            stg_q      <= '0;
            stg_vld_q  <= 1'b0;
            stg_last_q <= 1'b0;
            sh_q       <= '0;
            sh_vld_q   <= 1'b0;
            sh_last_q  <= 1'b0;
            beat_q     <= '0;
        end else begin
            stg_q      <= stg_d;
            stg_vld_q  <= stg_vld_d;
            stg_last_q <= stg_last_d;
            sh_q       <= sh_d;
            sh_vld_q   <= sh_vld_d;
            sh_last_q  <= sh_last_d;
            beat_q     <= beat_d;
        end
    end

    assign slot_busy_o     = slot_vld;
    assign slot_take_o     = load;
    assign last_hs_o       = word_end & sh_last_q;
    assign m_axis_tvalid_o = sh_vld_q;
    assign m_axis_tdata_o  = sh_q[W-1:0];
    assign m_axis_tlast_o  = sh_vld_q & sh_last_q & (beat_q == BEAT_IDX_W'(BEATS_PER_WORD - 1));

endmodule

// File: rtl/save_store.sv
// Output write-back engine: streams buffer words as AXIS beats to the write
// master. Define SAVE_LEN_CHECK_EN to reject instructions whose byte count mismatches.
module save_store
    import save_pkg::*;
#(
    parameter int SAVE_INST_LENGTH   = 96,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_XFER_SIZE_WIDTH  = 32
) (
    input  logic                                         kernel_clk,
    input  logic                                         kernel_rst,
    input  logic                                         ap_start,
    output logic                                         ap_done,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]                ctrl_addr_offset,
    input  logic [SAVE_INST_LENGTH-1:0]                  ctrl_instruction,
    output logic                                         save_read_buffer_r_en,
    output logic [BUF_ADDR_W-1:0]                        save_read_buffer_r_addr,
    input  logic [BEATS_PER_WORD*C_M_AXI_DATA_WIDTH-1:0] save_read_buffer_r_data,
    output logic                                         wr_start,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]                wr_addr,
    output logic [C_XFER_SIZE_WIDTH-1:0]                 wr_size,
    input  logic                                         wr_done,
    output logic                                         m_axis_tvalid,
    input  logic                                         m_axis_tready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]                m_axis_tdata,
    output logic                                         m_axis_tlast,
    output logic                                         save_err
);

    save_state_t                   state_q, state_d;
    logic [BUF_ADDR_W-1:0]         buf_start_q, buf_start_d;
    logic [FIELD_W-1:0]            buf_len_q, buf_len_d;
    logic [FIELD_W-1:0]            rd_idx_q, rd_idx_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [C_XFER_SIZE_WIDTH-1:0]  wr_size_q, wr_size_d;
    logic                          flag_q, flag_d;
    logic                          pend_q, pend_last_q;

    logic rd_en, len_bad, slot_busy, slot_take, last_hs;
    logic unused_inst;

    assign unused_inst = ^{ctrl_instruction[BUF_START_LSB-1:0],
                           ctrl_instruction[BUF_LEN_LSB-1:BUF_START_LSB+BUF_ADDR_W]};

`ifdef SAVE_LEN_CHECK_EN
    logic err_q;

    assign len_bad = (32'(wr_size_q[FIELD_W-1:0]) !=
                      save_len_bytes(buf_len_q, C_M_AXI_DATA_WIDTH / 8));

    always_ff @(posedge kernel_clk or posedge kernel_rst) begin
        if (kernel_rst) begin
            err_q <= 1'b0;
        end else if (state_q == S_IDLE && ap_start) begin
            err_q <= 1'b0;
        end else if (state_q == S_DECODE && len_bad) begin
            err_q <= 1'b1;
        end
    end

    assign save_err = err_q;
`else
    assign len_bad  = 1'b0;
    assign save_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        buf_start_d = buf_start_q;
        buf_len_d   = buf_len_q;
        rd_idx_d    = rd_idx_q;
        wr_addr_d   = wr_addr_q;
        wr_size_d   = wr_size_q;
        rd_en       = 1'b0;
        wr_start    = 1'b0;
        ap_done     = 1'b0;
        // wr_done may beat the tlast handshake, so it is remembered from RUN on.
        flag_d      = flag_q | (wr_done & (state_q == S_RUN || state_q == S_DRAIN));

        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    buf_start_d = ctrl_instruction[BUF_START_LSB +: BUF_ADDR_W];
                    buf_len_d   = ctrl_instruction[BUF_LEN_LSB +: FIELD_W];
                    wr_addr_d   = ctrl_addr_offset +
                                  C_M_AXI_ADDR_WIDTH'(ctrl_instruction[DRAM_START_LSB +: FIELD_W]);
                    wr_size_d   = C_XFER_SIZE_WIDTH'(ctrl_instruction[DRAM_BYTES_LSB +: FIELD_W]);
                    rd_idx_d    = '0;
                    flag_d      = 1'b0;
                    state_d     = S_DECODE;
                end
            end
            S_DECODE: begin
                if (len_bad || buf_len_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    wr_start = 1'b1;
                    rd_en    = 1'b1;
                    rd_idx_d = rd_idx_q + 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (rd_idx_q < buf_len_q && (!slot_busy || slot_take)) begin
                    rd_en    = 1'b1;
                    rd_idx_d = rd_idx_q + 1'b1;
                end
                if (last_hs) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (flag_q || wr_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                ap_done = 1'b1;
                flag_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge kernel_clk or posedge kernel_rst) begin
        if (kernel_rst) begin
            state_q     <= S_IDLE;
            buf_start_q <= '0;
            buf_len_q   <= '0;
            rd_idx_q    <= '0;
            wr_addr_q   <= '0;
            wr_size_q   <= '0;
            flag_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_start_q <= buf_start_d;
            buf_len_q   <= buf_len_d;
            rd_idx_q    <= rd_idx_d;
            wr_addr_q   <= wr_addr_d;
            wr_size_q   <= wr_size_d;
            flag_q      <= flag_d;
            pend_q      <= rd_en;
            pend_last_q <= rd_en && ((rd_idx_q + 1'b1) == buf_len_q);
        end
    end

    assign save_read_buffer_r_en   = rd_en;
    assign save_read_buffer_r_addr = buf_start_q + rd_idx_q[BUF_ADDR_W-1:0];
    assign wr_addr                 = wr_addr_q;
    assign wr_size                 = wr_size_q;

    save_unpacker #(
        .W(C_M_AXI_DATA_WIDTH)
    ) u_unpacker (
        .kernel_clk      (kernel_clk),
        .kernel_rst      (kernel_rst),
        .rd_valid_i      (pend_q),
        .rd_last_i       (pend_last_q),
        .rd_data_i       (save_read_buffer_r_data),
        .slot_busy_o     (slot_busy),
        .slot_take_o     (slot_take),
        .last_hs_o       (last_hs),
        .m_axis_tvalid_o (m_axis_tvalid),
        .m_axis_tready_i (m_axis_tready),
        .m_axis_tdata_o  (m_axis_tdata),
        .m_axis_tlast_o  (m_axis_tlast)
    );

endmodule

// File: tb/tb_save_store.sv
// Directed bench for save_store: buffer model, per-cycle stream/read capture,
// immediate-assertion checks against hand-computed expectations.
module tb_save_store;

    localparam int W  = 512;
    localparam int WW = 16 * W;

    logic            kernel_clk = 1'b0;
    logic            kernel_rst = 1'b1;
    logic            ap_start = 1'b0;
    logic            ap_done;
    logic [63:0]     ctrl_addr_offset = '0;
    logic [95:0]     ctrl_instruction = '0;
    logic            r_en;
    logic [12:0]     r_addr;
    logic [WW-1:0]   r_data = '0;
    logic            wr_start;
    logic [63:0]     wr_addr;
    logic [31:0]     wr_size;
    logic            wr_done = 1'b0;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b0;
    logic [W-1:0]    m_axis_tdata;
    logic            m_axis_tlast;
    logic            save_err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int n_beats, n_bad, first_tv, last_beat_c, tlast_n, tlast_at;
    int n_wrs, wrs_c, n_done, done_c, stall_viol, wraddr_bad, err_hi, wrdone_c;
    logic [12:0] rd_q[$];
    logic [63:0] wr_addr_s;
    logic [31:0] wr_size_s;

    save_store dut (
        .kernel_clk              (kernel_clk),
        .kernel_rst              (kernel_rst),
        .ap_start                (ap_start),
        .ap_done                 (ap_done),
        .ctrl_addr_offset        (ctrl_addr_offset),
        .ctrl_instruction        (ctrl_instruction),
        .save_read_buffer_r_en   (r_en),
        .save_read_buffer_r_addr (r_addr),
        .save_read_buffer_r_data (r_data),
        .wr_start                (wr_start),
        .wr_addr                 (wr_addr),
        .wr_size                 (wr_size),
        .wr_done                 (wr_done),
        .m_axis_tvalid           (m_axis_tvalid),
        .m_axis_tready           (m_axis_tready),
        .m_axis_tdata            (m_axis_tdata),
        .m_axis_tlast            (m_axis_tlast),
        .save_err                (save_err)
    );

    always #5 kernel_clk = ~kernel_clk;

    function automatic logic [W-1:0] beat_val(input logic [12:0] a, input int i);
        logic [31:0] x;
        x = {8'hA5, 3'b000, a, 4'h0, 4'(i)};
        return {(W/32){x}};
    endfunction

    function automatic logic [WW-1:0] mk_word(input logic [12:0] a);
        logic [WW-1:0] w;
        for (int i = 0; i < 16; i++) w[i*W +: W] = beat_val(a, i);
        return w;
    endfunction

    // Buffer model: registered read, data valid the cycle after r_en.
    always @(posedge kernel_clk) begin
        if (r_en) r_data <= mk_word(r_addr);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_run(input logic [15:0] bstart, input logic [15:0] blen,
                          input logic [15:0] dstart, input logic [15:0] dbytes,
                          input logic [63:0] off, input int bp, input int early,
                          input int restart_c, input int budget);
        int          after_done;
        int          sched;
        logic        prev_stall;
        logic [W-1:0] prev_data;
        logic        prev_last;
        logic [W-1:0] exp_beat;
        n_beats = 0; n_bad = 0; first_tv = -1; last_beat_c = -1; tlast_n = 0; tlast_at = -1;
        n_wrs = 0; wrs_c = -1; n_done = 0; done_c = -1; stall_viol = 0; wraddr_bad = 0;
        err_hi = 0; wrdone_c = -1; wr_addr_s = '0; wr_size_s = '0;
        rd_q.delete();
        after_done = -1; sched = -1; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        ctrl_instruction = {dbytes, dstart, blen, bstart, 32'hDEAD_BEEF};
        ctrl_addr_offset = off;
        for (int c = 0; c < budget; c++) begin
            @(negedge kernel_clk);
            if (prev_stall && !(m_axis_tvalid && m_axis_tdata === prev_data &&
                                m_axis_tlast === prev_last)) stall_viol++;
            ap_start      = (c == 0) || (c == restart_c);
            m_axis_tready = (bp != 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
            wr_done       = ((early != 0) && m_axis_tvalid && m_axis_tready && m_axis_tlast) ||
                            (c == sched);
            if (wr_done) wrdone_c = c;
            #1;
            if (m_axis_tvalid && m_axis_tready) begin
                if (first_tv < 0) first_tv = c;
                exp_beat = beat_val(bstart[12:0] + 13'(n_beats / 16), n_beats % 16);
                if (m_axis_tdata !== exp_beat) n_bad++;
                if (m_axis_tlast) begin
                    tlast_n++;
                    tlast_at = n_beats;
                    if (early == 0) sched = c + 3;
                end
                last_beat_c = c;
                n_beats++;
            end
            if (r_en) rd_q.push_back(r_addr);
            if (wr_start) begin
                n_wrs++;
                wrs_c     = c;
                wr_addr_s = wr_addr;
                wr_size_s = wr_size;
            end else if (n_wrs > 0 && n_done == 0 && wr_addr !== wr_addr_s) begin
                wraddr_bad++;
            end
            if (save_err) err_hi++;
            if (ap_done) begin
                n_done++;
                done_c = c;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            if (n_done > 0 && after_done < 0) after_done = c;
            if (after_done >= 0 && c >= after_done + 20) break;
        end
        ap_start = 1'b0;
        wr_done  = 1'b0;
    endtask

    initial begin
        int dones;
        // Reset state
        repeat (3) @(negedge kernel_clk);
        #1;
        chk("rst_ctrl_outs", {58'd0, ap_done, r_en, wr_start, m_axis_tvalid, m_axis_tlast, save_err}, 64'd0);
        chk("rst_r_addr", 64'(r_addr), 64'd0);
        chk("rst_wr_addr", wr_addr, 64'd0);
        chk("rst_wr_size", 64'(wr_size), 64'd0);
        chk("rst_tdata", 64'(|m_axis_tdata), 64'd0);
        @(negedge kernel_clk);
        kernel_rst = 1'b0;
        repeat (2) @(negedge kernel_clk);

        // Basic: 2 words, no backpressure
        do_run(16'h0010, 16'd2, 16'h0040, 16'd2048, 64'h0000_0001_0000_0000, 0, 0, -1, 200);
        $display("basic: beats=%0d reads=%0d first_tv=%0d last=%0d done=%0d", n_beats, rd_q.size(), first_tv, last_beat_c, done_c);
        chk("basic_beats", 64'(n_beats), 64'd32);
        chk("basic_bad_beats", 64'(n_bad), 64'd0);
        chk("basic_nreads", 64'(rd_q.size()), 64'd2);
        chk("basic_rd0", 64'(rd_q[0]), 64'h10);
        chk("basic_rd1", 64'(rd_q[1]), 64'h11);
        chk("basic_first_tvalid", 64'(first_tv), 64'd3);
        chk("basic_last_beat", 64'(last_beat_c), 64'd34);
        chk("basic_tlast_cnt", 64'(tlast_n), 64'd1);
        chk("basic_tlast_pos", 64'(tlast_at), 64'd31);
        chk("basic_wr_start_cnt", 64'(n_wrs), 64'd1);
        chk("basic_wr_start_cyc", 64'(wrs_c), 64'd1);
        chk("basic_wr_addr", wr_addr_s, 64'h0000_0001_0000_0040);
        chk("basic_wr_size", 64'(wr_size_s), 64'd2048);
        chk("basic_wr_addr_stable", 64'(wraddr_bad), 64'd0);
        chk("basic_done_cnt", 64'(n_done), 64'd1);
        chk("basic_done_cyc", 64'(done_c), 64'd38);

        // Backpressure: 3 words, random tready
        do_run(16'h0100, 16'd3, 16'h0000, 16'd3072, 64'd0, 1, 0, -1, 600);
        $display("backpressure: beats=%0d reads=%0d stall_viol=%0d done=%0d", n_beats, rd_q.size(), stall_viol, done_c);
        chk("bp_beats", 64'(n_beats), 64'd48);
        chk("bp_bad_beats", 64'(n_bad), 64'd0);
        chk("bp_nreads", 64'(rd_q.size()), 64'd3);
        chk("bp_rd2", 64'(rd_q[2]), 64'h102);
        chk("bp_stall_stable", 64'(stall_viol), 64'd0);
        chk("bp_tlast_pos", 64'(tlast_at), 64'd47);
        chk("bp_done_cnt", 64'(n_done), 64'd1);

        // Zero length
        do_run(16'h0005, 16'd0, 16'h0000, 16'd0, 64'd0, 0, 0, -1, 40);
        $display("zero: wr_start=%0d reads=%0d done=%0d", n_wrs, rd_q.size(), done_c);
        chk("zero_wr_start", 64'(n_wrs), 64'd0);
        chk("zero_nreads", 64'(rd_q.size()), 64'd0);
        chk("zero_beats", 64'(n_beats), 64'd0);
        chk("zero_done_cyc", 64'(done_c), 64'd2);
        chk("zero_done_cnt", 64'(n_done), 64'd1);

        // Buffer address wrap and wr_addr carry discard
        do_run(16'h1FFF, 16'd2, 16'h0020, 16'd2048, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0, -1, 200);
        $display("wrap: reads=%0d beats=%0d wr_addr=0x%0h", rd_q.size(), n_beats, wr_addr_s);
        chk("wrap_rd0", 64'(rd_q[0]), 64'h1FFF);
        chk("wrap_rd1", 64'(rd_q[1]), 64'h0000);
        chk("wrap_beats", 64'(n_beats), 64'd32);
        chk("wrap_bad_beats", 64'(n_bad), 64'd0);
        chk("wrap_wr_addr", wr_addr_s, 64'h10);

        // Early wr_done on the last handshake, plus an ap_start during RUN
        do_run(16'h0020, 16'd1, 16'h0000, 16'd1024, 64'd0, 0, 1, 8, 100);
        $display("early: wr_done@%0d done@%0d dones=%0d wr_starts=%0d", wrdone_c, done_c, n_done, n_wrs);
        chk("early_wr_done_cyc", 64'(wrdone_c), 64'd18);
        chk("early_done_cyc", 64'(done_c), 64'd20);
        chk("early_done_cnt", 64'(n_done), 64'd1);
        chk("early_wr_start_cnt", 64'(n_wrs), 64'd1);
        chk("early_nreads", 64'(rd_q.size()), 64'd1);
        chk("early_beats", 64'(n_beats), 64'd16);

        // Length mismatch: dram_bytes=1000 for one word
        do_run(16'h0030, 16'd1, 16'h0000, 16'd1000, 64'd0, 0, 0, -1, 200);
        $display("lencheck: err_cycles=%0d beats=%0d done=%0d", err_hi, n_beats, done_c);
`ifdef SAVE_LEN_CHECK_EN
        chk("len_err_seen", 64'(err_hi != 0), 64'd1);
        chk("len_err_held", 64'(save_err), 64'd1);
        chk("len_beats", 64'(n_beats), 64'd0);
        chk("len_wr_start", 64'(n_wrs), 64'd0);
        chk("len_done_cyc", 64'(done_c), 64'd2);
        do_run(16'h0000, 16'd0, 16'h0000, 16'd0, 64'd0, 0, 0, -1, 40);
        chk("len_err_cleared", 64'(save_err), 64'd0);
`else
        chk("len_err_low", 64'(err_hi), 64'd0);
        chk("len_beats", 64'(n_beats), 64'd16);
        chk("len_bad_beats", 64'(n_bad), 64'd0);
        chk("len_done_cnt", 64'(n_done), 64'd1);
`endif

        // Reset mid-word
        ctrl_instruction = {16'd2048, 16'h0000, 16'd2, 16'h0040, 32'h0};
        ctrl_addr_offset = 64'h1234;
        m_axis_tready    = 1'b1;
        @(negedge kernel_clk);
        ap_start = 1'b1;
        @(negedge kernel_clk);
        ap_start = 1'b0;
        repeat (9) @(negedge kernel_clk);
        #1;
        $display("midrst: before reset tvalid=%0d", m_axis_tvalid);
        chk("midrst_active", 64'(m_axis_tvalid), 64'd1);
        kernel_rst = 1'b1;
        #1;
        chk("midrst_ctrl_outs", {58'd0, ap_done, r_en, wr_start, m_axis_tvalid, m_axis_tlast, save_err}, 64'd0);
        chk("midrst_r_addr", 64'(r_addr), 64'd0);
        chk("midrst_wr_addr", wr_addr, 64'd0);
        chk("midrst_wr_size", 64'(wr_size), 64'd0);
        chk("midrst_tdata", 64'(|m_axis_tdata), 64'd0);
        @(negedge kernel_clk);
        kernel_rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge kernel_clk);
            #1;
            if (ap_done || m_axis_tvalid || r_en) dones++;
        end
        $display("midrst: post-reset activity cycles=%0d", dones);
        chk("midrst_quiet", 64'(dones), 64'd0);

        // Recovery after reset
        do_run(16'h0050, 16'd1, 16'h0000, 16'd1024, 64'd0, 0, 0, -1, 100);
        $display("recover: beats=%0d done=%0d", n_beats, done_c);
        chk("recover_beats", 64'(n_beats), 64'd16);
        chk("recover_bad_beats", 64'(n_bad), 64'd0);
        chk("recover_done_cnt", 64'(n_done), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/save_store.md
# save_store

Output write-back engine: the DRAM-bound counterpart of the weight loader. On a control instruction it reads wide 16×`C_M_AXI_DATA_WIDTH` words from an on-chip buffer and unpacks each into 16 beats. It streams the beats over AXI4-Stream into the AXI write master, which writes them to DRAM. It sits between the buffer read port and the write master, and is driven by the ctrl module's start/done handshake.

## Interface
Parameters:
- `SAVE_INST_LENGTH`, 96, instruction width
- `C_M_AXI_ADDR_WIDTH`, 64, DRAM address width
- `C_M_AXI_DATA_WIDTH`, 512, beat width
- `C_XFER_SIZE_WIDTH`, 32, write-master size width

Ports (clock and reset already decided):
- `kernel_clk` in 1: clock
- `kernel_rst` in 1: reset, asynchronous, active-high
- `ap_start` in 1: start request, sampled only in IDLE
- `ap_done` out 1: one-cycle completion pulse
- `ctrl_addr_offset` in `C_M_AXI_ADDR_WIDTH`: DRAM base
- `ctrl_instruction` in `SAVE_INST_LENGTH`: fields `[47:32]` buf_start, `[63:48]` buf_len (words), `[79:64]` dram_start, `[95:80]` dram_bytes
- `save_read_buffer_r_en` out 1: buffer read enable
- `save_read_buffer_r_addr` out 13: buffer word address
- `save_read_buffer_r_data` in 16×`C_M_AXI_DATA_WIDTH`: read data, valid 1 cycle after r_en
- `wr_start` out 1: one-cycle write-master start pulse
- `wr_addr` out `C_M_AXI_ADDR_WIDTH`: `ctrl_addr_offset + dram_start`, stable from DECODE to done
- `wr_size` out `C_XFER_SIZE_WIDTH`: zero-extended dram_bytes
- `wr_done` in 1: write-master completion pulse
- `m_axis_tvalid` out 1; `m_axis_tready` in 1; `m_axis_tdata` out `C_M_AXI_DATA_WIDTH`; `m_axis_tlast` out 1
- `save_err` out 1: length-mismatch flag (see Configuration)

## Operation
- **States:** IDLE → DECODE → RUN → DRAIN → DONE → IDLE.
- **IDLE:**
  - On `ap_start`, latch the instruction fields and offset, then go to DECODE.
  - `ap_start` in any other state is ignored.
- **DECODE (1 cycle):**
  - `buf_len == 0`: go to DONE; no `wr_start` and no reads.
  - Otherwise: pulse `wr_start`, issue the first read at `buf_start`, go to RUN.
- **RUN datapath:** 16-beat shift register plus one staging word register.
  - Word beat i is `r_data[i*W +: W]`; beat 0 is sent first.
  - A read is issued whenever staging is free, or will be freed this cycle, and words remain.
  - Read address is `buf_start[12:0] + word_idx`, wrapping modulo 2^13.
  - The shift register reloads from staging in the same cycle its beat 15 handshakes, giving one beat per cycle sustained.
- **AXIS rules:**
  - `tdata`/`tlast` hold stable while `tvalid && !tready`; `tvalid` never drops without a handshake.
  - `tlast` = beat 15 of word `buf_len-1`.
- **Exit to DRAIN / DONE:**
  - After the `tlast` handshake, go to DRAIN.
  - `wr_done` is captured in a sticky flag in any state after `wr_start`, so it is never lost even if it arrives while still in RUN.
  - DRAIN → DONE when the flag is set.
- **DONE:** pulse `ap_done`, clear the flag, return to IDLE.
- **Arithmetic:**
  - `word_idx` and `beat_idx` are 13-bit and 4-bit counters.
  - `wr_addr` is a full-width add with carry discarded.

## Timing
- **Reset values:** all outputs 0 (`ap_done`, `r_en`, `r_addr`, `wr_start`, `wr_addr`, `wr_size`, `tvalid`, `tdata`, `tlast`, `save_err`); state IDLE.
- **Reset mid-operation:** immediate abort, no partial `ap_done`; the write master is reset by the same reset.
- **Latency (no backpressure):**
  - `ap_start`@t → `wr_start`@t+1 and first `r_en`@t+1.
  - First `tvalid`@t+3.
  - Last beat @t+2+16·buf_len.
  - `ap_done` the cycle after DRAIN sees the flag.
- `buf_len == 0`: `ap_done`@t+2.
- Backpressure stalls the read issue; no data is lost and no extra reads are made.

## Configuration
- **`SAVE_LEN_CHECK_EN` defined:**
  - In DECODE, if `dram_bytes != buf_len*16*(W/8)` (computed at 32 bits), assert `save_err` until the next `ap_start`.
  - Skip the transfer and go to DONE.
- **Undefined:** `save_err` tied 0; the transfer runs with the given sizes unchecked.

## Structure
- **Package `save_pkg`:** instruction field offsets/widths, `BEATS_PER_WORD=16`, `BUF_ADDR_W=13`, state enum `save_state_t`.
- **Sub-module `save_unpacker`:** staging register, shift register, beat counter, AXIS output; reports free/last-beat status to the FSM.

## Test plan
- **Basic:** buf_start=0x10, buf_len=2, dram_bytes=2048, tready=1 → 32 beats in beat order, reads at 0x10 and 0x11, `tlast` on beat 32, `ap_done` one cycle after `wr_done`.
- **Backpressure:** random `tready` (50%), buf_len=3 → 48 beats with tdata stable during stalls, exactly 3 reads.
- **Zero length:** buf_len=0 → no `wr_start`, no `r_en`, `ap_done` at t+2.
- **Wrap-around:** buf_start=0x1FFF, buf_len=2 → reads at 0x1FFF then 0x0000.
- **Early `wr_done` and ignored start:** `wr_done` pulsed on the last handshake cycle, plus an `ap_start` during RUN → a single `ap_done` and no second run.
- **Reset and length check:**
  - Reset asserted mid-word: all outputs 0 immediately.
  - With `SAVE_LEN_CHECK_EN`, dram_bytes=1000 and buf_len=1: `save_err`=1, no beats, `ap_done` pulse.
